// File: rtl/mlaccel_pkg.sv
// Shared geometry for the accelerator scratch memory: 4 word-interleaved banks
// of 16-bit words, addressed in words, four lanes per access.
package mlaccel_pkg;

    localparam int WORD_BITS    = 16;
    localparam int LANES        = 4;
    localparam int ADDR_BITS    = 16;
    localparam int BANK_ROWS    = 16384;
    localparam int READ_LATENCY = 2;

    localparam int ROW_BITS     = $clog2(BANK_ROWS);
    localparam int BANK_BITS    = $clog2(LANES);
    localparam int BYTES        = WORD_BITS / 8;

    // Row inside a bank for a given word address (low bits select the bank).
    function automatic logic [ROW_BITS-1:0] word_row(input logic [ADDR_BITS-1:0] word_addr);
        return word_addr[ADDR_BITS-1:BANK_BITS];
    endfunction

endpackage

// File: rtl/mlaccel_membank.sv
// 16K x 16 single-port RAM with per-byte write enables and registered,
// read-first output; shaped so it maps onto one iCE40 SPRAM block.
module mlaccel_membank
    import mlaccel_pkg::*;
(
    input  logic                 clock,
    input  logic [ROW_BITS-1:0]  addr,
    input  logic [BYTES-1:0]     wen,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem [0:BANK_ROWS-1];
    logic [WORD_BITS-1:0] rdata_reg;

    // The output register has no reset so the array stays a pure RAM macro.
    always_ff @(posedge clock) begin
        rdata_reg <= mem[addr];
    end

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
            always_ff @(posedge clock) begin
                if (wen[gi]) begin
                    mem[addr][8*gi +: 8] <= wdata[8*gi +: 8];
                end
            end
        end
    endgenerate

    assign rdata = rdata_reg;

endmodule

// File: rtl/mlaccel_memory.sv
// Four-lane, unaligned-capable 64K x 16 memory built from four interleaved banks.
// Lanes are rotated onto banks by addr[1:0] and rotated back on the read path.
module mlaccel_memory
    import mlaccel_pkg::*;
(
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [ADDR_BITS-1:0]       addr,
    input  logic [LANES*BYTES-1:0]     wen,
    input  logic [LANES*WORD_BITS-1:0] wdata,
    output logic [LANES*WORD_BITS-1:0] rdata
);

    logic [ADDR_BITS-1:0]       lane_addr [LANES];
    logic [ROW_BITS-1:0]        bank_row  [LANES];
    logic [BYTES-1:0]           bank_wen  [LANES];
    logic [WORD_BITS-1:0]       bank_wdata[LANES];
    logic [WORD_BITS-1:0]       bank_rdata[LANES];
    logic [BANK_BITS-1:0]       rot;
    logic [BANK_BITS-1:0]       rot_reg;
    logic                       valid_reg;
    logic [LANES*WORD_BITS-1:0] rdata_next;
    logic [LANES*WORD_BITS-1:0] rdata_reg;

    assign rot = addr[BANK_BITS-1:0];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_addr[gi] = addr + ADDR_BITS'(gi);
        end

        for (genvar gi = 0; gi < LANES; gi++) begin : g_bank
            // Bank gi serves the lane whose word address ends in gi.
            logic [BANK_BITS-1:0] lane_sel;
            assign lane_sel = BANK_BITS'(gi) - rot;

            assign bank_row[gi]   = word_row(lane_addr[lane_sel]);
            assign bank_wen[gi]   = wen[{lane_sel, 1'b0} +: BYTES] & {BYTES{resetn}};
            assign bank_wdata[gi] = wdata[{lane_sel, 4'b0000} +: WORD_BITS];

            mlaccel_membank u_bank (
                .clock (clock),
                .addr  (bank_row[gi]),
                .wen   (bank_wen[gi]),
                .wdata (bank_wdata[gi]),
                .rdata (bank_rdata[gi])
            );
        end

        for (genvar gi = 0; gi < LANES; gi++) begin : g_unscramble
            logic [BANK_BITS-1:0] src_bank;
            assign src_bank = rot_reg + BANK_BITS'(gi);
            assign rdata_next[WORD_BITS*gi +: WORD_BITS] = bank_rdata[src_bank];
        end
    endgenerate

    // valid_reg masks the bank output that was captured before reset released.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rot_reg   <= '0;
            valid_reg <= 1'b0;
            rdata_reg <= '0;
        end else begin
            rot_reg   <= rot;
            valid_reg <= 1'b1;
            rdata_reg <= valid_reg ? rdata_next : '0;
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: tb/tb_mlaccel_memory.sv
// Directed bench for mlaccel_memory: a vector table of single accesses plus
// hand-written pipelined, read-after-write and reset sequences.
module tb_mlaccel_memory;

    logic        clock = 1'b0;
    logic        resetn;
    logic [15:0] addr;
    logic [7:0]  wen;
    logic [63:0] wdata;
    logic [63:0] rdata;

    int total = 0;
    int bad   = 0;

    mlaccel_memory dut (
        .clock  (clock),
        .resetn (resetn),
        .addr   (addr),
        .wen    (wen),
        .wdata  (wdata),
        .rdata  (rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wen;
        logic [63:0] wdata;
        logic [63:0] mask;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp,
                         input logic [63:0] mask);
        total++;
        if ((got & mask) !== (exp & mask)) begin
            bad++;
            $display("FAIL %s: rdata=%h masked=%h expected=%h", name, got, got & mask, exp & mask);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] w, input logic [63:0] d);
        addr  = a;
        wen   = w;
        wdata = d;
    endtask

    initial begin
        // addr, wen, wdata, compare mask, expected (read-first for writes)
        vecs[0]  = '{16'h0100, 8'hFF, 64'h1111_2222_3333_4444, 64'h0, 64'h0};
        vecs[1]  = '{16'h0100, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444};
        vecs[2]  = '{16'h0101, 8'h00, 64'h0, 64'h0000_FFFF_FFFF_FFFF, 64'h0000_1111_2222_3333};
        vecs[3]  = '{16'h0100, 8'h02, 64'h0000_0000_0000_ABCD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444};
        vecs[4]  = '{16'h0100, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_AB44};
        vecs[5]  = '{16'hFFFF, 8'h0F, 64'h0000_0000_6666_5555, 64'h0, 64'h0};
        vecs[6]  = '{16'h0000, 8'h00, 64'h0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_6666};
        vecs[7]  = '{16'hFFFE, 8'h00, 64'h0, 64'h0000_FFFF_FFFF_0000, 64'h0000_6666_5555_0000};
        vecs[8]  = '{16'h0102, 8'h30, 64'h0000_7777_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_1111_2222};
        vecs[9]  = '{16'h0103, 8'h00, 64'h0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_7777_1111};
        vecs[10] = '{16'h0000, 8'h0C, 64'h0000_0000_9999_0000, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_6666};
        vecs[11] = '{16'hFFFF, 8'h00, 64'h0, 64'h0000_FFFF_FFFF_FFFF, 64'h0000_9999_6666_5555};

        resetn = 1'b0;
        drive(16'h0, 8'h00, 64'h0);
        step();
        step();
        check("reset_state", rdata, 64'h0, '1);
        resetn = 1'b1;
        step();
        step();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].addr, vecs[i].wen, vecs[i].wdata);
            step();
            drive(vecs[i].addr, 8'h00, 64'h0);
            step();
            $display("vec %0d addr=%h wen=%h rdata=%h", i, vecs[i].addr, vecs[i].wen, rdata);
            check($sformatf("vec%0d", i), rdata, vecs[i].exp, vecs[i].mask);
        end

        // Back-to-back reads at 0,4,8 after seeding those rows.
        drive(16'h0000, 8'hFF, 64'hA003_A002_A001_A000); step();
        drive(16'h0004, 8'hFF, 64'hB003_B002_B001_B000); step();
        drive(16'h0008, 8'hFF, 64'hC003_C002_C001_C000); step();
        drive(16'h0000, 8'h00, 64'h0); step();
        drive(16'h0004, 8'h00, 64'h0); step();
        $display("b2b r0 rdata=%h", rdata);
        check("b2b_r0", rdata, 64'hA003_A002_A001_A000, '1);
        drive(16'h0008, 8'h00, 64'h0); step();
        $display("b2b r4 rdata=%h", rdata);
        check("b2b_r4", rdata, 64'hB003_B002_B001_B000, '1);
        drive(16'h0008, 8'h00, 64'h0); step();
        $display("b2b r8 rdata=%h", rdata);
        check("b2b_r8", rdata, 64'hC003_C002_C001_C000, '1);

        // Write, overwrite, then read immediately: read-first, then new data.
        drive(16'h0301, 8'hFF, 64'h1234_5678_9ABC_DEF0); step();
        drive(16'h0301, 8'hFF, 64'h0F0F_1E1E_2D2D_3C3C); step();
        drive(16'h0301, 8'h00, 64'h0); step();
        $display("raw old rdata=%h", rdata);
        check("read_first", rdata, 64'h1234_5678_9ABC_DEF0, '1);
        step();
        $display("raw new rdata=%h", rdata);
        check("read_after_write", rdata, 64'h0F0F_1E1E_2D2D_3C3C, '1);

        // Reset mid-stream with writes requested: outputs clear, memory keeps data.
        drive(16'h0400, 8'hFF, 64'hCAFE_BABE_DEAD_BEEF); step();
        drive(16'h0400, 8'h00, 64'h0); step();
        step();
        check("pre_reset_read", rdata, 64'hCAFE_BABE_DEAD_BEEF, '1);
        drive(16'h0400, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A);
        resetn = 1'b0;
        #1;
        check("async_reset_clear", rdata, 64'h0, '1);
        step();
        step();
        check("reset_hold", rdata, 64'h0, '1);
        drive(16'h0400, 8'h00, 64'h0);
        resetn = 1'b1;
        step();
        $display("post reset edge1 rdata=%h", rdata);
        check("post_reset_edge1", rdata, 64'h0, '1);
        step();
        $display("post reset edge2 rdata=%h", rdata);
        check("post_reset_mem_kept", rdata, 64'hCAFE_BABE_DEAD_BEEF, '1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
